// File: rtl/sc_pkg.sv
// sc_pkg: shared types and constants for the slow-control readback path.
// Holds the default chain length, the receive FSM state encoding and the
// CRC-16-CCITT constants and single-bit update used when SC_RB_CRC_EN is defined.
package sc_pkg;

    localparam int          SC_DATA_LENGTH = 929;
    localparam logic [15:0] SC_CRC_POLY    = 16'h1021;
    localparam logic [15:0] SC_CRC_INIT    = 16'hFFFF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } sc_state_e;

    // Number of bytes needed to carry len chain bits (last one zero-padded).
    function automatic int SC_BYTES(input int len);
        return (len + 7) / 8;
    endfunction

    // One MSB-first CRC-16-CCITT step for a single received bit.
    function automatic logic [15:0] sc_crc_next(input logic [15:0] crc, input logic bit_in);
        logic feedback;
        feedback = crc[15] ^ bit_in;
        return feedback ? ({crc[14:0], 1'b0} ^ SC_CRC_POLY) : {crc[14:0], 1'b0};
    endfunction

endpackage

// File: rtl/sc_edge_sync.sv
// sc_edge_sync: brings the asynchronous chain clock and return data into the
// clk domain through SYNC_STAGES flops each, and produces a registered,
// one-clk-wide pulse on the synchronized chain clock's rising edge together
// with the data bit sampled alongside it.
module sc_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic soft_rst,
    input  logic sc_clk_in,
    input  logic sc_din,
    output logic edge_pulse,
    output logic din_bit
);

    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] din_sync;
    logic                   clk_prev;

    // Synchronizer chains, rising-edge detector and aligned data capture.
    // Clock and data go through identical depths so the data bit that rides
    // out with the edge pulse is the one present when the chain clock rose.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: every flop here uses <= so all stages shift on the same edge;
        // blocking = would collapse the chain into a single stage.
        if (!rst_n) begin
            clk_sync   <= '0;
            din_sync   <= '0;
            clk_prev   <= 1'b0;
            edge_pulse <= 1'b0;
            din_bit    <= 1'b0;
        end else if (soft_rst) begin
            clk_sync   <= '0;
            din_sync   <= '0;
            clk_prev   <= 1'b0;
            edge_pulse <= 1'b0;
            din_bit    <= 1'b0;
        end else begin
            clk_sync   <= {clk_sync[SYNC_STAGES-2:0], sc_clk_in};
            din_sync   <= {din_sync[SYNC_STAGES-2:0], sc_din};
            clk_prev   <= clk_sync[SYNC_STAGES-1];
            edge_pulse <= clk_sync[SYNC_STAGES-1] & ~clk_prev;
            din_bit    <= din_sync[SYNC_STAGES-1];
        end
    end

endmodule

// File: rtl/sc_readback_deser.sv
// sc_readback_deser: receive side of the slow-control shift chain.
// Deserializes the chip's serial return MSB-first into bytes and offers them
// on a valid/ready interface; a trailing partial byte is emitted left-aligned
// and zero-padded. Optional CRC-16-CCITT over the received chain bits is
// built only when the macro SC_RB_CRC_EN is defined; otherwise rb_crc is 0.
module sc_readback_deser
    import sc_pkg::*;
#(
    parameter int DATA_LENGTH = SC_DATA_LENGTH,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        soft_rst,
    input  logic        rb_start,
    input  logic        sc_clk_in,
    input  logic        sc_din,
    output logic [7:0]  rb_data,
    output logic        rb_valid,
    input  logic        rb_ready,
    output logic        rb_overflow,
    output logic        rb_done,
    output logic [9:0]  rb_bit_count,
    output logic [15:0] rb_crc
);

    localparam int         REM        = DATA_LENGTH % 8;
    localparam logic [9:0] LAST_COUNT = 10'(DATA_LENGTH);

    sc_state_e  state;
    logic [7:0] shift_reg;
    logic [7:0] shift_next;
    logic [9:0] count_next;
    logic [7:0] byte_q;
    logic       byte_cmp;
    logic       edge_pulse;
    logic       din_bit;
    logic       session_start;
    logic       shift_en;

    sc_edge_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_edge_sync (
        .clk        (clk),
        .rst_n      (rst_n),
        .soft_rst   (soft_rst),
        .sc_clk_in  (sc_clk_in),
        .sc_din     (sc_din),
        .edge_pulse (edge_pulse),
        .din_bit    (din_bit)
    );

    assign session_start = (state == ST_IDLE) && rb_start;
    assign shift_en      = (state == ST_SHIFT) && rb_start && edge_pulse;
    assign shift_next    = {shift_reg[6:0], din_bit};
    assign count_next    = rb_bit_count + 10'd1;

    // Receive FSM: counts and shifts chain bits, flags each completed byte
    // (byte_cmp/byte_q) for the output stage one cycle later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            shift_reg    <= '0;
            rb_bit_count <= '0;
            byte_q       <= '0;
            byte_cmp     <= 1'b0;
            rb_done      <= 1'b0;
        end else if (soft_rst) begin
            state        <= ST_IDLE;
            shift_reg    <= '0;
            rb_bit_count <= '0;
            byte_q       <= '0;
            byte_cmp     <= 1'b0;
            rb_done      <= 1'b0;
        end else begin
            byte_cmp <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (rb_start) begin
                        state        <= ST_SHIFT;
                        shift_reg    <= '0;
                        rb_bit_count <= '0;
                    end
                end
                ST_SHIFT: begin
                    if (!rb_start) begin
                        state <= ST_IDLE;
                    end else if (edge_pulse) begin
                        shift_reg    <= shift_next;
                        rb_bit_count <= count_next;
                        if (count_next[2:0] == 3'd0) begin
                            byte_cmp <= 1'b1;
                            byte_q   <= shift_next;
                        end
                        if (count_next == LAST_COUNT) begin
                            if (REM == 0) begin
                                state   <= ST_DONE;
                                rb_done <= 1'b1;
                            end else begin
                                state <= ST_FLUSH;
                            end
                        end
                    end
                end
                ST_FLUSH: begin
                    if (!rb_start) begin
                        state <= ST_IDLE;
                    end else begin
                        // Left-align the REM leftover bits, zero pad below.
                        byte_cmp <= 1'b1;
                        byte_q   <= shift_reg << (8 - REM);
                        state    <= ST_DONE;
                        rb_done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (!rb_start) begin
                        state   <= ST_IDLE;
                        rb_done <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Output holding register: load a completed byte when the slot is free or
    // being accepted this cycle; otherwise drop it and flag overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rb_data     <= '0;
            rb_valid    <= 1'b0;
            rb_overflow <= 1'b0;
        end else if (soft_rst) begin
            rb_data     <= '0;
            rb_valid    <= 1'b0;
            rb_overflow <= 1'b0;
        end else begin
            if (byte_cmp && (!rb_valid || rb_ready)) begin
                rb_data  <= byte_q;
                rb_valid <= 1'b1;
            end else if (rb_valid && rb_ready) begin
                rb_valid <= 1'b0;
            end

            if (session_start) begin
                rb_overflow <= 1'b0;
            end else if (byte_cmp && rb_valid && !rb_ready) begin
                rb_overflow <= 1'b1;
            end
        end
    end

`ifdef SC_RB_CRC_EN
    logic [15:0] crc_q;

    // CRC over real chain bits only; padding in FLUSH never reaches it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_q <= SC_CRC_INIT;
        end else if (soft_rst) begin
            crc_q <= SC_CRC_INIT;
        end else if (session_start) begin
            crc_q <= SC_CRC_INIT;
        end else if (shift_en) begin
            crc_q <= sc_crc_next(crc_q, din_bit);
        end
    end

    assign rb_crc = crc_q;
`else
    assign rb_crc = 16'h0000;
`endif

endmodule

// File: tb/tb_sc_readback_deser.sv
// tb_sc_readback_deser: directed bench for sc_readback_deser. Instance u_dut
// uses the default 929-bit chain; u_dut_b uses a 16-bit chain for the
// byte-aligned end-of-session case. Honours SC_RB_CRC_EN when defined.
module tb_sc_readback_deser;

`ifdef SC_RB_CRC_EN
    localparam bit          CRC_EN  = 1'b1;
    localparam logic [15:0] CRC_RST = 16'hFFFF;
`else
    localparam bit          CRC_EN  = 1'b0;
    localparam logic [15:0] CRC_RST = 16'h0000;
`endif

    logic        clk = 1'b0;
    logic        rst_n, soft_rst;
    logic        rb_start, sc_clk_in, sc_din, rb_ready;
    logic [7:0]  rb_data;
    logic        rb_valid, rb_overflow, rb_done;
    logic [9:0]  rb_bit_count;
    logic [15:0] rb_crc;

    logic        rb_start_b, sc_clk_in_b, sc_din_b, rb_ready_b;
    logic [7:0]  rb_data_b;
    logic        rb_valid_b, rb_overflow_b, rb_done_b;
    logic [9:0]  rb_bit_count_b;
    logic [15:0] rb_crc_b;

    logic [7:0]  rx_q[$];
    logic [7:0]  rx_b[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    always #5 clk = ~clk;

    sc_readback_deser #(.DATA_LENGTH(929), .SYNC_STAGES(2)) u_dut (
        .clk(clk), .rst_n(rst_n), .soft_rst(soft_rst), .rb_start(rb_start),
        .sc_clk_in(sc_clk_in), .sc_din(sc_din), .rb_data(rb_data),
        .rb_valid(rb_valid), .rb_ready(rb_ready), .rb_overflow(rb_overflow),
        .rb_done(rb_done), .rb_bit_count(rb_bit_count), .rb_crc(rb_crc)
    );

    sc_readback_deser #(.DATA_LENGTH(16), .SYNC_STAGES(2)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .soft_rst(soft_rst), .rb_start(rb_start_b),
        .sc_clk_in(sc_clk_in_b), .sc_din(sc_din_b), .rb_data(rb_data_b),
        .rb_valid(rb_valid_b), .rb_ready(rb_ready_b), .rb_overflow(rb_overflow_b),
        .rb_done(rb_done_b), .rb_bit_count(rb_bit_count_b), .rb_crc(rb_crc_b)
    );

    // Consumer model: record every byte handed over at the coming posedge.
    always @(negedge clk) begin
        #2;
        if (rb_valid && rb_ready) rx_q.push_back(rb_data);
        if (rb_valid_b && rb_ready_b) rx_b.push_back(rb_data_b);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
        logic [16:0] t;
        t = {c, 1'b0};
        if (t[16] ^ b) t[15:0] = t[15:0] ^ 16'h1021;
        return t[15:0];
    endfunction

    // One chain bit: data changes with the falling chain clock, sampled on the rise.
    task automatic send_bit(input int sel, input logic b, input int half);
        if (sel == 0) begin sc_clk_in = 1'b0; sc_din = b; end
        else begin sc_clk_in_b = 1'b0; sc_din_b = b; end
        repeat (half) @(negedge clk);
        if (sel == 0) sc_clk_in = 1'b1; else sc_clk_in_b = 1'b1;
        repeat (half) @(negedge clk);
    endtask

    task automatic send_byte(input int sel, input logic [7:0] v, input int half);
        for (int i = 7; i >= 0; i--) send_bit(sel, v[i], half);
    endtask

    initial begin
        logic [7:0]  pat;
        logic [15:0] crc_exp;
        logic [7:0]  last_b;
        logic [7:0]  last_c3;
        int          bad;

        rst_n = 1'b0; soft_rst = 1'b0;
        rb_start = 1'b0; sc_clk_in = 1'b0; sc_din = 1'b0; rb_ready = 1'b0;
        rb_start_b = 1'b0; sc_clk_in_b = 1'b0; sc_din_b = 1'b0; rb_ready_b = 1'b0;

        // Reset held while the chain clock toggles.
        repeat (3) @(negedge clk);
        for (int i = 0; i < 20; i++) send_bit(0, i[0], 4);
        #2;
        check("rst_data", rb_data, 8'h00);
        check("rst_valid", rb_valid, 1'b0);
        check("rst_overflow", rb_overflow, 1'b0);
        check("rst_done", rb_done, 1'b0);
        check("rst_bit_count", rb_bit_count, 10'd0);
        check("rst_crc", rb_crc, CRC_RST);

        // Out of reset but idle: edges are ignored.
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 20; i++) send_bit(0, i[0], 4);
        #2;
        check("idle_bit_count", rb_bit_count, 10'd0);
        check("idle_valid", rb_valid, 1'b0);

        // Full 929-bit load of 0xA5 at 40 clk per chain bit.
        @(negedge clk);
        rx_q.delete();
        rb_ready = 1'b1;
        rb_start = 1'b1;
        repeat (2) @(negedge clk);
        pat = 8'hA5;
        crc_exp = 16'hFFFF;
        for (int i = 0; i < 929; i++) begin
            crc_exp = crc_step(crc_exp, pat[7 - (i % 8)]);
            send_bit(0, pat[7 - (i % 8)], 20);
        end
        for (int k = 0; k < 50 && !rb_done; k++) @(negedge clk);
        repeat (10) @(negedge clk);
        #2;
        check("full_done", rb_done, 1'b1);
        check("full_bit_count", rb_bit_count, 10'd929);
        check("full_overflow", rb_overflow, 1'b0);
        check("full_num_bytes", rx_q.size(), 117);
        bad = 0;
        for (int j = 0; j < 116 && j < rx_q.size(); j++) if (rx_q[j] !== 8'hA5) bad++;
        check("full_bytes_a5", bad, 0);
        last_b = (rx_q.size() > 116) ? rx_q[116] : 8'hxx;
        check("full_last_byte", last_b, 8'h80);
        check("full_crc", rb_crc, CRC_EN ? crc_exp : 16'h0000);

        // Edges in DONE change nothing.
        for (int i = 0; i < 5; i++) send_bit(0, 1'b1, 4);
        repeat (6) @(negedge clk);
        #2;
        check("done_count_frozen", rb_bit_count, 10'd929);
        check("done_no_new_bytes", rx_q.size(), 117);

        @(negedge clk) rb_start = 1'b0;
        @(negedge clk) #2;
        check("done_cleared", rb_done, 1'b0);

        // Backpressure: byte 0x22 held, 0x33 dropped, then 0x44 flows.
        @(negedge clk);
        rx_q.delete();
        rb_ready = 1'b1;
        rb_start = 1'b1;
        repeat (2) @(negedge clk);
        send_byte(0, 8'h11, 4);
        repeat (8) @(negedge clk);
        rb_ready = 1'b0;
        send_byte(0, 8'h22, 4);
        repeat (8) @(negedge clk);
        #2;
        check("bp_valid", rb_valid, 1'b1);
        check("bp_data_first", rb_data, 8'h22);
        check("bp_no_overflow_yet", rb_overflow, 1'b0);
        send_byte(0, 8'h33, 4);
        repeat (8) @(negedge clk);
        #2;
        check("bp_data_stable", rb_data, 8'h22);
        check("bp_overflow", rb_overflow, 1'b1);
        @(negedge clk) rb_ready = 1'b1;
        send_byte(0, 8'h44, 4);
        repeat (8) @(negedge clk);
        #2;
        check("bp_num_bytes", rx_q.size(), 3);
        check("bp_sequence", (rx_q.size() == 3) ? {rx_q[0], rx_q[1], rx_q[2]} : 24'hxxxxxx, 24'h112244);

        // Abort after 100 bits, then restart.
        for (int i = 0; i < 68; i++) send_bit(0, i[1], 4);
        repeat (8) @(negedge clk);
        @(negedge clk) rb_start = 1'b0;
        @(negedge clk) #2;
        check("abort_done", rb_done, 1'b0);
        check("abort_bit_count", rb_bit_count, 10'd100);
        check("abort_overflow_sticky", rb_overflow, 1'b1);
        for (int i = 0; i < 3; i++) send_bit(0, 1'b1, 4);
        #2;
        check("abort_edges_ignored", rb_bit_count, 10'd100);
        @(negedge clk) rb_start = 1'b1;
        @(negedge clk) #2;
        check("restart_bit_count", rb_bit_count, 10'd0);
        check("restart_overflow", rb_overflow, 1'b0);

        // Accept of 0x5A lines up with completion of 0xC3.
        @(negedge clk);
        rx_q.delete();
        rb_ready = 1'b0;
        send_byte(0, 8'h5A, 4);
        repeat (8) @(negedge clk);
        #2;
        check("sim_first_valid", rb_valid, 1'b1);
        check("sim_first_data", rb_data, 8'h5A);
        last_c3 = 8'hC3;
        for (int i = 7; i >= 1; i--) send_bit(0, last_c3[i], 4);
        sc_clk_in = 1'b0;
        sc_din = last_c3[0];
        repeat (4) @(negedge clk);
        sc_clk_in = 1'b1;
        repeat (4) @(negedge clk);
        rb_ready = 1'b1;
        @(negedge clk) rb_ready = 1'b0;
        #2;
        check("sim_valid_kept", rb_valid, 1'b1);
        check("sim_new_data", rb_data, 8'hC3);
        check("sim_no_overflow", rb_overflow, 1'b0);
        check("sim_accepted", (rx_q.size() == 1) ? rx_q[0] : 8'hxx, 8'h5A);

        // Soft reset mid-session clears count and output.
        @(negedge clk) rb_ready = 1'b1;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 5; i++) send_bit(0, 1'b1, 4);
        @(negedge clk) soft_rst = 1'b1;
        @(negedge clk) soft_rst = 1'b0;
        #2;
        check("soft_rst_count", rb_bit_count, 10'd0);
        check("soft_rst_valid", rb_valid, 1'b0);
        @(negedge clk) rb_start = 1'b0;

        // 16-bit chain: two bytes, DONE one cycle after the last edge pulse.
        @(negedge clk);
        rb_ready_b = 1'b1;
        rb_start_b = 1'b1;
        repeat (2) @(negedge clk);
        crc_exp = 16'hFFFF;
        pat = 8'hDE;
        for (int i = 7; i >= 0; i--) crc_exp = crc_step(crc_exp, pat[i]);
        pat = 8'hAD;
        for (int i = 7; i >= 0; i--) crc_exp = crc_step(crc_exp, pat[i]);
        send_byte(1, 8'hDE, 4);
        for (int i = 7; i >= 1; i--) send_bit(1, pat[i], 4);
        sc_clk_in_b = 1'b0;
        sc_din_b = pat[0];
        repeat (4) @(negedge clk);
        sc_clk_in_b = 1'b1;
        repeat (3) @(negedge clk);
        #2;
        check("b_done_not_yet", rb_done_b, 1'b0);
        @(negedge clk) #2;
        check("b_done_rise", rb_done_b, 1'b1);
        check("b_valid_latency_early", rb_valid_b, 1'b0);
        check("b_bit_count", rb_bit_count_b, 10'd16);
        @(negedge clk) #2;
        check("b_valid_latency", rb_valid_b, 1'b1);
        check("b_last_data", rb_data_b, 8'hAD);
        for (int i = 0; i < 5; i++) send_bit(1, 1'b1, 4);
        repeat (6) @(negedge clk);
        #2;
        check("b_count_frozen", rb_bit_count_b, 10'd16);
        check("b_done_held", rb_done_b, 1'b1);
        check("b_num_bytes", rx_b.size(), 2);
        check("b_bytes", (rx_b.size() == 2) ? {rx_b[0], rx_b[1]} : 16'hxxxx, 16'hDEAD);
        check("b_overflow", rb_overflow_b, 1'b0);
        check("b_crc", rb_crc_b, CRC_EN ? crc_exp : 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
